// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-channel round-robin front end for a simple dual-port RAM with 1-cycle reads.
// Optional macro RAM_ARB_RD_FWD_EN forwards same-cycle write data to a colliding read.
module ram_port_arbiter #(
    parameter int ADDR_LEN = 16,
    parameter int DATA_LEN = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                a_wr_valid,
    input  logic [ADDR_LEN-1:0] a_wr_addr,
    input  logic [DATA_LEN-1:0] a_wr_data,
    output logic                a_wr_ready,
    input  logic                a_rd_valid,
    input  logic [ADDR_LEN-1:0] a_rd_addr,
    output logic                a_rd_ready,
    output logic                a_rvalid,
    output logic [DATA_LEN-1:0] a_rdata,
    input  logic                b_wr_valid,
    input  logic [ADDR_LEN-1:0] b_wr_addr,
    input  logic [DATA_LEN-1:0] b_wr_data,
    output logic                b_wr_ready,
    input  logic                b_rd_valid,
    input  logic [ADDR_LEN-1:0] b_rd_addr,
    output logic                b_rd_ready,
    output logic                b_rvalid,
    output logic [DATA_LEN-1:0] b_rdata,
    output logic                ram_wr_en,
    output logic [ADDR_LEN-1:0] ram_wr_addr,
    output logic [DATA_LEN-1:0] ram_wr_data,
    output logic [ADDR_LEN-1:0] ram_rd_addr,
    input  logic [DATA_LEN-1:0] ram_q
);
    // wr_last / rd_last: 1 when channel B won the most recent grant
    logic                wr_last, rd_last;
    logic                rd_grant;
    logic                rd_pend_vld, rd_pend_ch;
    logic [ADDR_LEN-1:0] rd_addr_q;
    logic [DATA_LEN-1:0] rdata;

    always_comb begin
        a_wr_ready  = a_wr_valid && (!b_wr_valid || wr_last);
        b_wr_ready  = b_wr_valid && !a_wr_ready;
        a_rd_ready  = a_rd_valid && (!b_rd_valid || rd_last);
        b_rd_ready  = b_rd_valid && !a_rd_ready;
        rd_grant    = a_rd_ready || b_rd_ready;
        ram_wr_en   = a_wr_ready || b_wr_ready;
        ram_wr_addr = a_wr_ready ? a_wr_addr : b_wr_ready ? b_wr_addr : '0;
        ram_wr_data = a_wr_ready ? a_wr_data : b_wr_ready ? b_wr_data : '0;
        ram_rd_addr = a_rd_ready ? a_rd_addr : b_rd_ready ? b_rd_addr : rd_addr_q;
        a_rvalid    = rd_pend_vld && !rd_pend_ch;
        b_rvalid    = rd_pend_vld && rd_pend_ch;
        a_rdata     = a_rvalid ? rdata : '0;
        b_rdata     = b_rvalid ? rdata : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_last     <= 1'b1;
            rd_last     <= 1'b1;
            rd_pend_vld <= 1'b0;
            rd_pend_ch  <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            if (ram_wr_en) wr_last <= b_wr_ready;
            if (rd_grant) begin
                rd_last    <= b_rd_ready;
                rd_pend_ch <= b_rd_ready;
                rd_addr_q  <= ram_rd_addr;
            end
            rd_pend_vld <= rd_grant;
        end
    end

`ifdef RAM_ARB_RD_FWD_EN
    logic                fwd_hit;
    logic [DATA_LEN-1:0] fwd_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= ram_wr_en && rd_grant && (ram_wr_addr == ram_rd_addr);
            fwd_data <= ram_wr_data;
        end
    end

    assign rdata = fwd_hit ? fwd_data : ram_q;
`else
    assign rdata = ram_q;
`endif

endmodule
